// File: rtl/adrv9009_tfir.sv
// Transmit FIR interpolator: zero-stuff by L (1/2/4) plus an NTAPS-tap FIR.
// The coefficient bank is loaded from the shared RAM before filtering starts.
module adrv9009_tfir #(
    parameter int NTAPS = 48
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_tfir,
    input  logic [1:0]         mode_tfir,
    input  logic signed [15:0] in,
    output logic               in_ready,
    output logic signed [15:0] out,
    output logic               out_valid,
    output logic [6:0]         addr_out,
    input  logic signed [15:0] ram_coeff
);
    localparam int CW = $clog2(NTAPS + 1);
    localparam int AW = $clog2(NTAPS);

    typedef enum logic [1:0] {ST_BYPASS, ST_LOAD, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q;
    logic [1:0]          ph_q, ph_d;
    logic [1:0]          lsh, lmask;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic signed [15:0]  out_q, out_d;
    logic signed [15:0]  h_q [NTAPS];
    logic signed [15:0]  d_q [NTAPS];
    logic signed [15:0]  d_d [NTAPS];
    logic signed [31:0]  prod [NTAPS];
    logic signed [38:0]  acc;
    logic signed [39:0]  rnd;
    logic signed [25:0]  shr;
    logic signed [15:0]  sat;
    logic                capture;
    logic [AW-1:0]       wr_idx;

    // Latched mode selects the zero-stuff shift: tap k belongs to phase k mod L.
    always_comb begin
        case (mode_q)
            2'b01:   begin lsh = 2'd1; lmask = 2'b01; end
            2'b10:   begin lsh = 2'd2; lmask = 2'b11; end
            default: begin lsh = 2'd0; lmask = 2'b00; end
        endcase
    end

    assign capture = (state_q == ST_RUN) && in_ready_q;
    assign wr_idx  = AW'(cnt_q - 1'b1);

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
            localparam logic [1:0] KLO = 2'(gi % 4);
            logic signed [15:0] dsel;

            if (gi == 0) begin : g_head
                assign d_d[gi] = capture ? in : d_q[gi];
            end else begin : g_body
                assign d_d[gi] = capture ? d_q[gi-1] : d_q[gi];
            end

            always_comb begin
                case (lsh)
                    2'd1:    dsel = d_d[gi/2];
                    2'd2:    dsel = d_d[gi/4];
                    default: dsel = d_d[gi];
                endcase
            end

            always_comb begin
                prod[gi] = 32'sd0;
                if ((KLO & lmask) == ph_q) begin
                    prod[gi] = h_q[gi] * dsel;
                end
            end
        end
    endgenerate

    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc = acc + 39'(prod[k]);
        end
        rnd = 40'(acc) + 40'sd8192;
        shr = 26'(rnd >>> 14);
        if (shr > 26'sd32767) begin
            sat = 16'sh7fff;
        end else if (shr < -26'sd32768) begin
            sat = -16'sh8000;
        end else begin
            sat = 16'(shr);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BYPASS;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode 11 and a dropped enable win over everything; a mode change restarts the load.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BYPASS: begin
                if (en_tfir && (mode_tfir != 2'b11)) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (!en_tfir || (mode_tfir == 2'b11)) begin
                    state_d = ST_BYPASS;
                end else if (mode_tfir != mode_q) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else if (state_q == ST_LOAD) begin
                    if (cnt_q == CW'(NTAPS)) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
        ph_d = '0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            ph_d = (ph_q + 2'd1) & lmask;
        end
    end

    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_d       = '0;
        case (state_d)
            ST_BYPASS: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b1;
                out_d       = in;
            end
            ST_RUN: begin
                in_ready_d  = (ph_d == 2'd0);
                out_valid_d = 1'b1;
                if (state_q == ST_RUN) begin
                    out_d = sat;
                end
            end
            default: ;
        endcase
        addr_out = '0;
        if ((state_q == ST_LOAD) && (cnt_q < CW'(NTAPS))) begin
            addr_out = 7'(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            mode_q      <= '0;
            ph_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                h_q[i] <= '0;
                d_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            if ((state_d == ST_LOAD) && (cnt_d == '0)) begin
                mode_q <= mode_tfir;
            end
            // RAM read latency: coefficient k arrives one cycle after address k.
            if ((state_q == ST_LOAD) && (cnt_q != '0)) begin
                h_q[wr_idx] <= ram_coeff;
            end
            for (int i = 0; i < NTAPS; i++) begin
                d_q[i] <= ((state_q == ST_RUN) && (state_d == ST_RUN)) ? d_d[i] : 16'sd0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
endmodule

// File: tb/tb_adrv9009_tfir.sv
// Directed bench for adrv9009_tfir: reset, bypass table, impulse responses at L=1/4,
// mode-change reload with delay-line clear, reserved mode and saturation.
module tb_adrv9009_tfir;
    localparam int NTAPS = 48;

    logic               clk = 1'b0;
    logic               reset;
    logic               en_tfir;
    logic [1:0]         mode_tfir;
    logic signed [15:0] in_s;
    logic               in_ready;
    logic signed [15:0] out_s;
    logic               out_valid;
    logic [6:0]         addr_out;
    logic signed [15:0] ram_coeff = '0;
    logic signed [15:0] coeff_mem [128];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic signed [15:0] din;
        logic signed [15:0] dout;
    } byp_vec_t;

    byp_vec_t byp [8];

    always #5 clk = ~clk;

    always @(posedge clk) ram_coeff <= coeff_mem[addr_out];

    adrv9009_tfir #(.NTAPS(NTAPS)) dut (
        .clk       (clk),
        .reset     (reset),
        .en_tfir   (en_tfir),
        .mode_tfir (mode_tfir),
        .in        (in_s),
        .in_ready  (in_ready),
        .out       (out_s),
        .out_valid (out_valid),
        .addr_out  (addr_out),
        .ram_coeff (ram_coeff)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Advance until out_valid returns; report the number of invalid cycles seen.
    task automatic wait_run(input string name);
        int n;
        int nz;
        n  = 0;
        nz = 0;
        do begin
            tick();
            n++;
            if (!out_valid && (out_s != 0)) nz++;
        end while (!out_valid && (n < 300));
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_load_cycles"}, n - 1, NTAPS + 1);
        chk({name, "_load_out_zero"}, nz, 0);
        chk({name, "_first_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        byp[0] = '{16'sd0,      16'sd0};
        byp[1] = '{16'sd1,      16'sd1};
        byp[2] = '{16'sd2,      16'sd2};
        byp[3] = '{16'sd3,      16'sd3};
        byp[4] = '{16'sd32767,  16'sd32767};
        byp[5] = '{-16'sd32768, -16'sd32768};
        byp[6] = '{16'sh1234,   16'sd4660};
        byp[7] = '{-16'sd5,     -16'sd5};

        for (int k = 0; k < 128; k++) coeff_mem[k] = (k < NTAPS) ? 16'(k + 1) : 16'sd0;

        reset     = 1'b1;
        en_tfir   = 1'b1;
        mode_tfir = 2'b00;
        in_s      = '0;
        repeat (3) tick();
        chk("rst_out", int'(out_s), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_addr", int'(addr_out), 0);

        reset = 1'b0;
        tick();
        chk("load_valid", int'(out_valid), 0);
        chk("load_addr0", int'(addr_out), 0);
        tick();
        chk("load_addr1", int'(addr_out), 1);
        tick();
        chk("load_addr2", int'(addr_out), 2);

        // Drop enable in the middle of the load.
        en_tfir = 1'b0;
        tick();
        chk("abort_valid", int'(out_valid), 1);
        chk("abort_ready", int'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            in_s = byp[i].din;
            tick();
            chk($sformatf("byp%0d_out", i), int'(out_s), int'(byp[i].dout));
            chk($sformatf("byp%0d_ready", i), int'(in_ready), 1);
        end

        // L=1 impulse response.
        in_s      = '0;
        mode_tfir = 2'b00;
        en_tfir   = 1'b1;
        wait_run("l1");
        chk("l1_idle_out", int'(out_s), 0);
        in_s = 16'sd16384;
        tick();
        chk("l1_imp0", int'(out_s), 1);
        in_s = '0;
        for (int k = 1; k < NTAPS; k++) begin
            tick();
            chk($sformatf("l1_imp%0d", k), int'(out_s), k + 1);
            chk($sformatf("l1_ready%0d", k), int'(in_ready), 1);
        end
        tick();
        chk("l1_tail", int'(out_s), 0);

        // L=2 leaves a sample in the delay line, then switch to L=4.
        mode_tfir = 2'b01;
        wait_run("l2");
        in_s = 16'sd16384;
        tick();
        chk("l2_imp0", int'(out_s), 1);
        chk("l2_ready0", int'(in_ready), 0);
        in_s = '0;
        tick();
        chk("l2_imp1", int'(out_s), 2);
        chk("l2_ready1", int'(in_ready), 1);

        mode_tfir = 2'b10;
        wait_run("l4");
        tick();
        chk("l4_cleared", int'(out_s), 0);
        chk("l4_ready_p1", int'(in_ready), 0);
        tick();
        tick();
        chk("l4_cleared2", int'(out_s), 0);
        tick();
        chk("l4_ready_p0", int'(in_ready), 1);
        in_s = 16'sd16384;
        for (int k = 0; k < NTAPS; k++) begin
            tick();
            in_s = '0;
            chk($sformatf("l4_imp%0d", k), int'(out_s), k + 1);
            chk($sformatf("l4_ready%0d", k), int'(in_ready), ((k % 4) == 3) ? 1 : 0);
        end
        tick();
        chk("l4_tail", int'(out_s), 0);

        // Reserved mode acts as bypass.
        mode_tfir = 2'b11;
        in_s      = 16'sh0777;
        tick();
        chk("m11_valid", int'(out_valid), 1);
        chk("m11_ready", int'(in_ready), 1);
        chk("m11_out", int'(out_s), 16'h0777);

        // Saturation with unity coefficients.
        for (int k = 0; k < 128; k++) coeff_mem[k] = (k < NTAPS) ? 16'sd16384 : 16'sd0;
        in_s      = '0;
        mode_tfir = 2'b00;
        wait_run("sat");
        in_s = 16'sd32767;
        tick();
        chk("sat_pos_first", int'(out_s), 32767);
        repeat (50) tick();
        chk("sat_pos_hold", int'(out_s), 32767);
        in_s = -16'sd32768;
        tick();
        chk("sat_swing", int'(out_s), 32767);
        repeat (50) tick();
        chk("sat_neg_hold", int'(out_s), -32768);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
